// File: rtl/sha256_host_ctrl.sv
// rtl/sha256_host_ctrl.sv - host controller: load message, start SHA-256 engine, read back and stream digest
// Optional watchdog in WAIT enabled by `define SHA_HOST_TIMEOUT_EN
module sha256_host_ctrl #(
  parameter int          MSG_WORDS      = 20,
  parameter logic [15:0] MSG_ADDR       = 16'h0000,
  parameter logic [15:0] OUT_ADDR       = 16'h0080,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  output logic        busy,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_data,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  output logic        sha_start,
  input  logic        sha_done,
  output logic        mem_clk,
  output logic        mem_host_own,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout_data,
  output logic        dout_last,
  output logic        err_timeout
);

  localparam int            KW     = $clog2(MSG_WORDS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(MSG_WORDS - 1);

  if (MSG_WORDS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("MSG_WORDS and TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_STREAM} state_t;

  state_t        r_state, w_next;
  logic [KW-1:0] r_k;
  logic [3:0]    r_j;
  logic [31:0]   r_buf [0:7];
  logic          r_mem_we, r_own, r_sha_start;
  logic [15:0]   r_mem_addr;
  logic [31:0]   r_wdata;
  logic          w_msg_hs, w_out_hs, w_tmo;

  assign w_msg_hs = (r_state == S_LOAD) && msg_valid;
  assign w_out_hs = (r_state == S_STREAM) && dout_ready;

  assign busy           = (r_state != S_IDLE);
  assign msg_ready      = (r_state == S_LOAD);
  assign message_addr   = MSG_ADDR;
  assign output_addr    = OUT_ADDR;
  assign sha_start      = r_sha_start;
  assign mem_clk        = clk;
  assign mem_host_own   = r_own;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_wdata;
  assign dout_valid     = (r_state == S_STREAM);
  assign dout_data      = r_buf[r_j[2:0]];
  assign dout_last      = (r_state == S_STREAM) && (r_j == 4'd7);

`ifdef SHA_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;

  assign w_tmo       = (r_state == S_WAIT) && !sha_done && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == S_WAIT) ? r_tmo_cnt + 1'b1 : '0;
      if (w_tmo)
        r_err <= 1'b1;
      else if (r_state == S_IDLE && go)
        r_err <= 1'b0;
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (go) w_next = S_LOAD;
      S_LOAD:   if (w_msg_hs && r_k == K_LAST) w_next = S_START;
      S_START:  w_next = S_WAIT;
      S_WAIT:   if (sha_done) w_next = S_READ;
                else if (w_tmo) w_next = S_IDLE;
      S_READ:   if (r_j == 4'd8) w_next = S_STREAM;
      S_STREAM: if (w_out_hs && r_j == 4'd7) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The start pulse is registered off START so it lands one cycle after the last write is on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_j         <= '0;
      r_mem_we    <= 1'b0;
      r_own       <= 1'b0;
      r_sha_start <= 1'b0;
      r_mem_addr  <= '0;
      r_wdata     <= '0;
      for (int i = 0; i < 8; i++) r_buf[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_mem_we    <= w_msg_hs;
      r_sha_start <= (r_state == S_START);
      r_own       <= (r_state == S_LOAD) || (w_next == S_READ);
      if (r_state == S_IDLE && go)
        r_k <= '0;
      if (w_msg_hs) begin
        r_mem_addr <= MSG_ADDR + 16'(r_k);
        r_wdata    <= msg_data;
        r_k        <= r_k + 1'b1;
      end
      if (r_state == S_WAIT && sha_done) begin
        r_j        <= '0;
        r_mem_addr <= OUT_ADDR;
      end
      // Read data trails the address by one cycle, so slot j-1 is captured while j is presented.
      if (r_state == S_READ) begin
        if (r_j != 4'd0)
          r_buf[3'(r_j - 4'd1)] <= mem_read_data;
        if (r_j < 4'd7)
          r_mem_addr <= OUT_ADDR + 16'(r_j) + 16'd1;
        r_j <= (r_j == 4'd8) ? 4'd0 : r_j + 4'd1;
      end
      if (w_out_hs)
        r_j <= (r_j == 4'd7) ? 4'd0 : r_j + 4'd1;
    end
  end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// tb/tb_sha256_host_ctrl.sv - directed self-checking bench for sha256_host_ctrl
// Timeout scenario runs only when SHA_HOST_TIMEOUT_EN is defined
module tb_sha256_host_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, go, msg_valid, sha_done, dout_ready;
  logic [31:0] msg_data, mem_read_data;
  logic        busy, msg_ready, sha_start, mem_clk, mem_host_own, mem_we;
  logic        dout_valid, dout_last, err_timeout;
  logic [15:0] message_addr, output_addr, mem_addr;
  logic [31:0] mem_write_data, dout_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int          w_cyc [$];
  logic [15:0] w_addr [$];
  logic [31:0] w_data [$];
  int          s_cyc [$];
  int          own_bad = 0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  sha256_host_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .busy(busy),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .message_addr(message_addr), .output_addr(output_addr),
    .sha_start(sha_start), .sha_done(sha_done),
    .mem_clk(mem_clk), .mem_host_own(mem_host_own), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .err_timeout(err_timeout)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_we) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(mem_addr);
      w_data.push_back(mem_write_data);
      if (!mem_host_own) own_bad++;
    end
    if (sha_start) s_cyc.push_back(cyc);
  endtask

  task automatic clear_log();
    w_cyc.delete(); w_addr.delete(); w_data.delete(); s_cyc.delete();
    own_bad = 0;
  endtask

  task automatic start_job();
    go = 1'b1;
    step();
    go = 1'b0;
    check_eq("go_busy", busy, 1);
    check_eq("go_ready", msg_ready, 1);
  endtask

  task automatic load_words(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      msg_valid = 1'b1;
      msg_data  = i + 1;
      step();
      if (toggle) begin
        msg_valid = 1'b0;
        step();
      end
    end
    msg_valid = 1'b0;
  endtask

  task automatic check_writes(input int n, input int spacing);
    check_eq("wr_count", w_cyc.size(), n);
    for (int i = 0; i < n && i < w_cyc.size(); i++) begin
      check_eq($sformatf("wr_addr%0d", i), w_addr[i], i);
      check_eq($sformatf("wr_data%0d", i), w_data[i], i + 1);
      if (i > 0) check_eq($sformatf("wr_gap%0d", i), w_cyc[i] - w_cyc[i-1], spacing);
    end
    check_eq("wr_own", own_bad, 0);
  endtask

  task automatic run_engine(input int delay, input bit poke_go);
    int s;
    int first;
    for (int n = 0; n < 20 && s_cyc.size() == 0; n++) step();
    check_eq("start_seen", s_cyc.size(), 1);
    if (s_cyc.size() == 0) return;
    s = s_cyc[0];
    if (w_cyc.size() > 0) check_eq("start_after_wr", s, w_cyc[w_cyc.size()-1] + 1);
    check_eq("start_ready", msg_ready, 0);
    check_eq("start_we", mem_we, 0);
    step();
    check_eq("wait_own", mem_host_own, 0);
    if (poke_go) begin
      go = 1'b1;
      step();
      go = 1'b0;
      check_eq("go_ignored_busy", busy, 1);
      check_eq("go_ignored_ready", msg_ready, 0);
    end
    while (cyc < s + delay) step();
    sha_done = 1'b1;
    step();
    sha_done = 1'b0;
    check_eq("read_own", mem_host_own, 1);
    check_eq("read_addr0", mem_addr, 16'h0080);
    check_eq("start_once", s_cyc.size(), 1);
    first = -1;
    for (int n = 0; n < 20; n++) begin
      if (dout_valid) begin
        first = cyc;
        break;
      end
      step();
    end
    check_eq("read_latency", first, s + delay + 10);
  endtask

  task automatic collect(input int stall_word, input int stall_len);
    int got = 0;
    int stall = 0;
    for (int n = 0; n < 60 && got < 8; n++) begin
      if (dout_valid) begin
        if (got == stall_word && stall < stall_len) begin
          dout_ready = 1'b0;
          stall++;
          check_eq("stall_data", dout_data, 32'hD000_0000 + stall_word);
          check_eq("stall_valid", dout_valid, 1);
        end else begin
          dout_ready = 1'b1;
          check_eq($sformatf("dout%0d", got), dout_data, 32'hD000_0000 + got);
          check_eq($sformatf("last%0d", got), dout_last, (got == 7));
          got++;
        end
      end else begin
        dout_ready = 1'b0;
      end
      step();
    end
    dout_ready = 1'b0;
    check_eq("dout_count", got, 8);
    check_eq("end_busy", busy, 0);
    check_eq("end_valid", dout_valid, 0);
    check_eq("end_last", dout_last, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[8'h80 + i] = 32'hD000_0000 + i;
    reset_n = 1'b0; go = 1'b0; msg_valid = 1'b0; msg_data = '0;
    sha_done = 1'b0; dout_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", msg_ready, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_write_data, 0);
    check_eq("rst_start", sha_start, 0);
    check_eq("rst_own", mem_host_own, 0);
    check_eq("rst_dvalid", dout_valid, 0);
    check_eq("rst_ddata", dout_data, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("msg_addr_const", message_addr, 16'h0000);
    check_eq("out_addr_const", output_addr, 16'h0080);
    reset_n = 1'b1;
    step();
    check_eq("idle_busy", busy, 0);

    // Job A: back-to-back words, stall digest word 3 for 5 cycles
    clear_log();
    start_job();
    load_words(20, 1'b0);
    check_writes(20, 1);
    run_engine(50, 1'b0);
    collect(3, 5);

    // Job B: valid toggling, go poked while busy
    clear_log();
    start_job();
    load_words(20, 1'b1);
    check_writes(20, 2);
    run_engine(50, 1'b1);
    collect(8, 0);

    // Reset mid-LOAD after 7 words, then restart
    clear_log();
    start_job();
    load_words(7, 1'b0);
    check_eq("pre_rst_wr", w_cyc.size(), 7);
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", msg_ready, 0);
    check_eq("arst_we", mem_we, 0);
    check_eq("arst_addr", mem_addr, 0);
    check_eq("arst_wdata", mem_write_data, 0);
    check_eq("arst_own", mem_host_own, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    clear_log();
    start_job();
    load_words(20, 1'b0);
    check_writes(20, 1);
    run_engine(50, 1'b0);
    collect(8, 0);

`ifdef SHA_HOST_TIMEOUT_EN
    begin
      int s;
      int hit;
      clear_log();
      start_job();
      load_words(20, 1'b0);
      for (int n = 0; n < 20 && s_cyc.size() == 0; n++) step();
      check_eq("tmo_start_seen", s_cyc.size(), 1);
      s = (s_cyc.size() > 0) ? s_cyc[0] : cyc;
      hit = -1;
      for (int n = 0; n < 40; n++) begin
        if (err_timeout) begin
          hit = cyc;
          break;
        end
        step();
      end
      check_eq("tmo_cycles", hit - s, 16);
      check_eq("tmo_idle", busy, 0);
      step();
      check_eq("tmo_sticky", err_timeout, 1);
      start_job();
      check_eq("tmo_cleared", err_timeout, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
